fetch_stage: RTL

Instruction fetch stage of the 5-stage pipelined core. It owns the program counter, issues in-order requests to instruction memory, and buffers returned instructions with their PCs. It presents them to the IF/ID pipeline register with a valid/ready handshake, so a stalled decode never loses a fetched word. A taken branch or jump from EX redirects the PC and squashes everything younger.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core-wide constants and the fetch buffer entry type.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr}; the caller guarantees no push when full
// and no pop when empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order imem requests under a credit limit and
// buffers tagged responses toward IF/ID. A redirect flushes and drops all younger work.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tag_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            credit;
    logic            fire;
    logic            push;
    logic            pop;

    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;

    // A same-cycle pop frees a slot; counting it sustains one fetch per cycle.
    assign credit    = (inflight_q + count - CW'(pop)) < DEPTH_C;
    assign imem_req  = !rst && !redirect && credit;
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;

    assign push      = imem_rvalid && !redirect && (discard_q == '0);
    assign push_data = '{pc: tag_q, instr: imem_rdata};

    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : INSTR_NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(fire) - CW'(imem_rvalid);
            if (redirect) begin
                pc_q      <= redirect_pc;
                tag_q     <= redirect_pc;
                discard_q <= inflight_q - CW'(imem_rvalid);
            end else begin
                if (fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (push) begin
                    tag_q <= tag_q + 32'd4;
                end
                if (imem_rvalid && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule
